// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters, visible-area flag,
// frame-start pulse and sync outputs delayed to match a registered RGB stage.
//
// Ports:
//   pixelClk   in   pixel clock, only clock
//   locked     in   sync active-low reset (low = reset)
//   xCor       out  [9:0] horizontal pixel coordinate
//   yCor       out  [9:0] vertical line coordinate
//   dValid     out  xCor/yCor inside visible area
//   hSync      out  horizontal sync, one cycle behind xCor
//   vSync      out  vertical sync, one cycle behind yCor
//   frameStart out  one-cycle pulse when (0,0) is presented
module vga_timing #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       pixelClk,
  input  logic       locked,
  output logic [9:0] xCor,
  output logic [9:0] yCor,
  output logic       dValid,
  output logic       hSync,
  output logic       vSync,
  output logic       frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_cfg
    $error("vga_timing: line or frame total exceeds 10-bit counter");
  end

  // 11-bit bounds so a total of exactly 1024 still compares correctly
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_END = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_END = 11'(V_TOTAL - 1);

  logic [9:0]  h;
  logic [9:0]  v;
  logic [10:0] hx;
  logic [10:0] vx;
  logic        h_wrap;
  logic        v_wrap;
  logic        h_act;
  logic        v_act;
  logic        hs1;
  logic        vs1;

  assign hx     = {1'b0, h};
  assign vx     = {1'b0, v};
  assign h_wrap = (hx == H_END);
  assign v_wrap = (vx == V_END);
  assign h_act  = (hx >= H_SS) && (hx < H_SE);
  assign v_act  = (vx >= V_SS) && (vx < V_SE);

  always_ff @(posedge pixelClk) begin
    if (!locked) begin
      h          <= '0;
      v          <= '0;
      xCor       <= '0;
      yCor       <= '0;
      dValid     <= 1'b0;
      frameStart <= 1'b0;
      hs1        <= ~SYNC_POL;
      vs1        <= ~SYNC_POL;
      hSync      <= ~SYNC_POL;
      vSync      <= ~SYNC_POL;
    end else begin
      h <= h_wrap ? '0 : h + 10'd1;
      if (h_wrap) begin
        v <= v_wrap ? '0 : v + 10'd1;
      end
      xCor       <= h;
      yCor       <= v;
      dValid     <= (hx < H_ACT) && (vx < V_ACT);
      frameStart <= (h == '0) && (v == '0);
      // stage 1 aligns with xCor/yCor; stage 2 matches downstream RGB reg
      hs1        <= h_act ? SYNC_POL : ~SYNC_POL;
      vs1        <= v_act ? SYNC_POL : ~SYNC_POL;
      hSync      <= hs1;
      vSync      <= vs1;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: default, small and mid configurations,
// per-edge scoreboard plus run-length and spacing checks on recorded history.
module tb_vga_timing;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       dv;
    logic       fs;
    logic       hs;
    logic       vs;
  } obs_t;

  logic pixelClk = 1'b0;
  logic locked   = 1'b0;

  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic dv0, hs0, vs0, fs0;
  logic dv1, hs1, vs1, fs1;
  logic dv2, hs2, vs2, fs2;

  int   sel = 0;
  obs_t obs;

  int tests = 0;
  int fails = 0;

  obs_t exp_q[$];
  obs_t hist[5000];
  int   nh = 0;

  int   cha, chf, chs, chb, cva, cvf, cvs, cvb, ht, vt;
  logic pol;
  int   mh, mv;
  logic phs, pvs;

  initial forever #5 pixelClk = ~pixelClk;

  vga_timing d0 (
    .pixelClk(pixelClk), .locked(locked),
    .xCor(x0), .yCor(y0), .dValid(dv0),
    .hSync(hs0), .vSync(vs0), .frameStart(fs0)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1)
  ) d1 (
    .pixelClk(pixelClk), .locked(locked),
    .xCor(x1), .yCor(y1), .dValid(dv1),
    .hSync(hs1), .vSync(vs1), .frameStart(fs1)
  );

  vga_timing #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(5),
    .SYNC_POL(1'b0)
  ) d2 (
    .pixelClk(pixelClk), .locked(locked),
    .xCor(x2), .yCor(y2), .dValid(dv2),
    .hSync(hs2), .vSync(vs2), .frameStart(fs2)
  );

  always_comb begin
    obs = '0;
    case (sel)
      1:       obs = '{x1, y1, dv1, fs1, hs1, vs1};
      2:       obs = '{x2, y2, dv2, fs2, hs2, vs2};
      default: obs = '{x0, y0, dv0, fs0, hs0, vs0};
    endcase
  end

  task automatic set_cfg(input int s);
    sel = s;
    case (s)
      1: begin
        cha = 8;  chf = 2; chs = 3; chb = 3;
        cva = 4;  cvf = 1; cvs = 1; cvb = 1; pol = 1'b1;
      end
      2: begin
        cha = 40; chf = 4; chs = 8; chb = 4;
        cva = 30; cvf = 3; cvs = 2; cvb = 5; pol = 1'b0;
      end
      default: begin
        cha = 640; chf = 16; chs = 96; chb = 48;
        cva = 480; cvf = 10; cvs = 2;  cvb = 33; pol = 1'b0;
      end
    endcase
    ht = cha + chf + chs + chb;
    vt = cva + cvf + cvs + cvb;
  endtask

  // reference raster: computes what the next edge should present
  task automatic model_edge(input logic lk);
    obs_t e;
    if (!lk) begin
      e = '{10'd0, 10'd0, 1'b0, 1'b0, ~pol, ~pol};
      mh = 0; mv = 0; phs = ~pol; pvs = ~pol;
    end else begin
      e.x  = 10'(mh);
      e.y  = 10'(mv);
      e.dv = (mh < cha) && (mv < cva);
      e.fs = (mh == 0) && (mv == 0);
      e.hs = phs;
      e.vs = pvs;
      phs = (mh >= cha + chf && mh < cha + chf + chs) ? pol : ~pol;
      pvs = (mv >= cva + cvf && mv < cva + cvf + cvs) ? pol : ~pol;
      mh++;
      if (mh == ht) begin
        mh = 0;
        mv++;
        if (mv == vt) mv = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic lk);
    obs_t e;
    obs_t o;
    locked = lk;
    model_edge(lk);
    @(posedge pixelClk);
    @(negedge pixelClk);
    o = obs;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL sb_empty: no expected entry");
    end else begin
      e = exp_q.pop_front();
      if (o !== e) begin
        fails++;
        $display("FAIL sb cfg%0d: got x=%0d y=%0d dv=%b fs=%b hs=%b vs=%b want x=%0d y=%0d dv=%b fs=%b hs=%b vs=%b",
                 sel, o.x, o.y, o.dv, o.fs, o.hs, o.vs,
                 e.x, e.y, e.dv, e.fs, e.hs, e.vs);
      end
    end
    if (nh < 5000) begin
      hist[nh] = o;
      nh++;
    end
  endtask

  task automatic test_reset();
    set_cfg(0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      tests++;
      if (obs !== obs_t'{10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
        fails++;
        $display("FAIL reset_low: got x=%0d y=%0d dv=%b fs=%b hs=%b vs=%b want zeros, syncs=1",
                 obs.x, obs.y, obs.dv, obs.fs, obs.hs, obs.vs);
      end
    end
    tick(1'b1);
    tests++;
    if (obs.x !== 10'd0 || obs.y !== 10'd0 || obs.dv !== 1'b1 || obs.fs !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: got x=%0d y=%0d dv=%b fs=%b want 0 0 1 1",
               obs.x, obs.y, obs.dv, obs.fs);
    end
  endtask

  task automatic test_line_timing();
    int i;
    int n;
    set_cfg(0);
    tick(1'b0);
    tick(1'b0);
    nh = 0;
    for (int k = 0; k < 1700; k++) tick(1'b1);
    n = 0;
    while (n < nh && hist[n].dv === 1'b1) n++;
    tests++;
    if (n !== 640) begin
      fails++;
      $display("FAIL dv_high_run: got %0d want 640", n);
    end
    i = n;
    while (i < nh && hist[i].dv === 1'b0) i++;
    tests++;
    if (i - n !== 160) begin
      fails++;
      $display("FAIL dv_low_run: got %0d want 160", i - n);
    end
    i = 0;
    while (i < nh && hist[i].x !== 10'd656) i++;
    tests++;
    if (i + 100 >= nh || hist[i].hs !== 1'b1 || hist[i + 1].hs !== 1'b0) begin
      fails++;
      $display("FAIL hs_start: idx %0d hs@656=%b hs@next=%b want 1 0",
               i, hist[i].hs, hist[i + 1].hs);
    end
    n = 0;
    while (i + 1 + n < nh && hist[i + 1 + n].hs === 1'b0) n++;
    tests++;
    if (n !== 96) begin
      fails++;
      $display("FAIL hs_low_run: got %0d want 96", n);
    end
    i = 0;
    while (i < nh - 1 && hist[i].x !== 10'd799) i++;
    tests++;
    if (hist[i + 1].x !== 10'd0 || hist[i + 1].y !== hist[i].y + 10'd1) begin
      fails++;
      $display("FAIL line_wrap: got x=%0d y=%0d want x=0 y=%0d",
               hist[i + 1].x, hist[i + 1].y, hist[i].y + 10'd1);
    end
  endtask

  task automatic test_frame_timing();
    int i;
    int n;
    int f1;
    set_cfg(2);
    tick(1'b0);
    nh = 0;
    for (int k = 0; k < 4600; k++) tick(1'b1);
    f1 = 1;
    while (f1 < nh && hist[f1].fs !== 1'b1) f1++;
    tests++;
    if (hist[0].fs !== 1'b1 || f1 !== 2240) begin
      fails++;
      $display("FAIL fs_spacing: got first=%b next idx=%0d want 1 2240", hist[0].fs, f1);
    end
    i = 0;
    while (i < nh - 1 && !(hist[i].x === 10'd0 && hist[i].y === 10'd33)) i++;
    tests++;
    if (hist[i].vs !== 1'b1 || hist[i + 1].vs !== 1'b0) begin
      fails++;
      $display("FAIL vs_start: idx %0d vs=%b next=%b want 1 0", i, hist[i].vs, hist[i + 1].vs);
    end
    n = 0;
    while (i + 1 + n < nh && hist[i + 1 + n].vs === 1'b0) n++;
    tests++;
    if (n !== 112) begin
      fails++;
      $display("FAIL vs_low_run: got %0d want 112", n);
    end
    i = 0;
    while (i < nh - 1 && !(hist[i].x === 10'd55 && hist[i].y === 10'd39)) i++;
    tests++;
    if (hist[i + 1].x !== 10'd0 || hist[i + 1].y !== 10'd0 || hist[i + 1].fs !== 1'b1) begin
      fails++;
      $display("FAIL frame_wrap: got x=%0d y=%0d fs=%b want 0 0 1",
               hist[i + 1].x, hist[i + 1].y, hist[i + 1].fs);
    end
  endtask

  task automatic test_mid_reset();
    logic found;
    set_cfg(2);
    tick(1'b0);
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      tick(1'b1);
      if (obs.x === 10'd20 && obs.y === 10'd12) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL mid_reach: got no (20,12) want found within 3000 cycles");
    end
    tick(1'b0);
    tests++;
    if (obs !== obs_t'{10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL mid_reset: got x=%0d y=%0d dv=%b fs=%b hs=%b vs=%b want 0 0 0 0 1 1",
               obs.x, obs.y, obs.dv, obs.fs, obs.hs, obs.vs);
    end
    tick(1'b1);
    tests++;
    if (obs.x !== 10'd0 || obs.y !== 10'd0 || obs.dv !== 1'b1 || obs.fs !== 1'b1) begin
      fails++;
      $display("FAIL mid_release: got x=%0d y=%0d dv=%b fs=%b want 0 0 1 1",
               obs.x, obs.y, obs.dv, obs.fs);
    end
    for (int k = 0; k < 100; k++) tick(1'b1);
  endtask

  task automatic test_small();
    int f1;
    int n;
    set_cfg(1);
    tick(1'b0);
    nh = 0;
    for (int k = 0; k < 300; k++) tick(1'b1);
    f1 = 1;
    while (f1 < nh && hist[f1].fs !== 1'b1) f1++;
    tests++;
    if (f1 !== 112) begin
      fails++;
      $display("FAIL small_frame: got %0d want 112", f1);
    end
    n = 0;
    for (int k = 16; k < 32; k++) if (hist[k].hs === 1'b1) n++;
    tests++;
    if (n !== 3) begin
      fails++;
      $display("FAIL small_hs: got %0d want 3", n);
    end
    n = 0;
    for (int k = 16; k < 32; k++) if (hist[k].dv === 1'b1) n++;
    tests++;
    if (n !== 8) begin
      fails++;
      $display("FAIL small_dv: got %0d want 8", n);
    end
    n = 0;
    for (int k = 112; k < 224; k++) if (hist[k].vs === 1'b1) n++;
    tests++;
    if (n !== 16) begin
      fails++;
      $display("FAIL small_vs: got %0d want 16", n);
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(1);
    for (int k = 0; k < 40; k++) tick((k % 7) != 3);
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_mid_reset();
    test_small();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
